ram_16k_loader: RTL

Sequential word loader that sits directly upstream of the 16K-word block-RAM data memory. It accepts a byte stream over a valid/ready handshake, packs byte pairs into 16-bit words (high byte first), and drives the RAM's `in`/`address`/`load` port to write them to consecutive addresses. It is used to preload program data into memory before the CPU is released from reset.

---
 rtl/ram_16k_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ram_16k_loader.sv
// ram_16k_loader: packs a valid/ready byte stream (high byte first) into
// 16-bit words and writes them to consecutive block-RAM addresses starting at
// BASE_ADDR (wrapping modulo 2^ADDR_W). A word_count of 0 loads 2^ADDR_W words.
// Optional readback verification is compiled in with `define LOADER_VERIFY_EN.
module ram_16k_loader #(
    parameter int          ADDR_W    = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [15:0]       ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    input  logic [15:0]       ram_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HI, S_LO, S_WRITE, S_RD, S_CMP, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HI, S_LO, S_WRITE, S_DONE
    } state_t;
`endif

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] index;
    logic [7:0]        hi_byte;
    logic [ADDR_W:0]   target;
    logic              last_wr;

    // A latched count of zero stands for a full 2^ADDR_W-word load.
    assign target  = (count == '0) ? FULL_CNT : {1'b0, count};
    // In WRITE the counter has not yet stepped, so compare one ahead.
    assign last_wr = ((words_written + 1'b1) == target);
    assign busy    = (state != S_IDLE);

`ifdef LOADER_VERIFY_EN
    logic last_cmp;
    logic err_q;
    // In CMP the counter already includes the current word.
    assign last_cmp = (words_written == target);
    assign error    = err_q;
`else
    logic unused_ram_out;
    assign unused_ram_out = ^ram_out;
    assign error          = 1'b0;
`endif

    // State register; asynchronous reset drops ram_load/byte_ready immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake/write-enable decode.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        ram_load   = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_HI;
            S_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = S_LO;
            end
            S_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                ram_load = 1'b1;
`ifdef LOADER_VERIFY_EN
                state_nxt = S_RD;
`else
                state_nxt = last_wr ? S_DONE : S_HI;
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_RD:  state_nxt = S_CMP;
            S_CMP: state_nxt = last_cmp ? S_DONE : S_HI;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: byte packing, address/data presentation, counters and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            index         <= '0;
            hi_byte       <= '0;
            ram_in        <= '0;
            ram_address   <= '0;
            done          <= 1'b0;
            words_written <= '0;
`ifdef LOADER_VERIFY_EN
            err_q         <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    count         <= word_count;
                    index         <= '0;
                    done          <= 1'b0;
                    words_written <= '0;
`ifdef LOADER_VERIFY_EN
                    err_q         <= 1'b0;
`endif
                end
                S_HI: if (byte_valid) hi_byte <= byte_in;
                // Address and data are registered here so they are stable
                // for the whole WRITE (and verify) window and hold afterwards.
                S_LO: if (byte_valid) begin
                    ram_in      <= {hi_byte, byte_in};
                    ram_address <= BASE + index;
                end
                S_WRITE: begin
                    words_written <= words_written + 1'b1;
`ifndef LOADER_VERIFY_EN
                    if (!last_wr) index <= index + 1'b1;
`endif
                end
`ifdef LOADER_VERIFY_EN
                S_CMP: begin
                    if (ram_out != ram_in) err_q <= 1'b1;
                    if (!last_cmp) index <= index + 1'b1;
                end
`endif
                S_DONE: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
